// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory port controller.
package imem_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam int          ADDR_W_DEF    = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_SDU = 2'd1,
        S_ACK = 2'd2
    } state_e;

endpackage

// File: rtl/imem_port_ctrl.sv
// Shares the single-port instruction memory between CPU fetch and the serial debug unit.
// Optional macro IMEM_READBACK_EN enables SDU read-back through the port.
module imem_port_ctrl
    import imem_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_stall,
    input  logic              sdu_req,
    input  logic              sdu_we,
    input  logic [ADDR_W-1:0] sdu_addr,
    input  logic [DATA_W-1:0] sdu_wdata,
    output logic              sdu_ack,
    output logic [DATA_W-1:0] sdu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  wr_cnt
);

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              sdu_rd_use;

`ifdef IMEM_READBACK_EN
    assign sdu_rd_use = 1'b1;
`else
    // Reads are handshaken only; the port stays with the CPU address.
    assign sdu_rd_use = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mem_addr  = cpu_pc;
        mem_wdata = sdu_wdata;
        mem_we    = 1'b0;
        cpu_stall = 1'b1;
        cpu_instr = NOP_INSTR;
        wr_cnt_d  = wr_cnt_q;
        unique case (state_q)
            S_CPU: begin
                cpu_stall = 1'b0;
                cpu_instr = mem_rdata;
                if (sdu_req) state_d = S_SDU;
            end
            S_SDU: begin
                if (sdu_we || sdu_rd_use) mem_addr = sdu_addr;
                mem_we  = sdu_we & rstn;
                state_d = S_ACK;
                if (sdu_we && (wr_cnt_q != {CNT_W{1'b1}}))
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
            S_ACK: begin
                if (!sdu_req) state_d = S_CPU;
            end
            default: state_d = S_CPU;
        endcase
        ack_d = (state_d == S_ACK);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_CPU;
            ack_q    <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

`ifdef IMEM_READBACK_EN
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (state_q == S_SDU && !sdu_we) rdata_d = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign sdu_rdata = rdata_q;
`else
    assign sdu_rdata = '0;
`endif

    assign sdu_ack = ack_q;
    assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Directed scoreboard bench for imem_port_ctrl with a behavioural memory model.
module tb_imem_port_ctrl;

    localparam int          DW  = 32;
    localparam int          AW  = 32;
    localparam int          CW  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] cpu_pc;
    logic [DW-1:0] cpu_instr;
    logic          cpu_stall;
    logic          sdu_req, sdu_we;
    logic [AW-1:0] sdu_addr;
    logic [DW-1:0] sdu_wdata;
    logic          sdu_ack;
    logic [DW-1:0] sdu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] wr_cnt;

    imem_port_ctrl dut (
        .clk(clk), .rstn(rstn), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
        .cpu_stall(cpu_stall), .sdu_req(sdu_req), .sdu_we(sdu_we),
        .sdu_addr(sdu_addr), .sdu_wdata(sdu_wdata), .sdu_ack(sdu_ack),
        .sdu_rdata(sdu_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    // Memory wrapper: async read, sync write, word index from byte address.
    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];
    int we_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            we_cnt = we_cnt + 1;
        end
    end

    logic [31:0] exp_mem [0:63];
    logic [63:0] exp_q [$];
    logic [31:0] last_rd = '0;
    logic [15:0] exp_wr  = '0;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] pc);
        logic [31:0] idx;
        @(posedge clk); #1;
        cpu_pc = pc;
        idx = pc;
        exp_q.push_back({32'h0, exp_mem[idx[7:2]]});
        @(negedge clk);
        chk("fetch_instr", cpu_instr, exp_q.pop_front());
        chk("fetch_stall", cpu_stall, 0);
        chk("fetch_ack", sdu_ack, 0);
    endtask

    // Starts just after a posedge when chained; otherwise aligns itself first.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, input bit chain);
        int w0;
        logic [31:0] a;
        if (!chain) begin @(posedge clk); #1; end
        a = addr;
        sdu_we = we; sdu_addr = addr; sdu_wdata = wd; sdu_req = 1'b1;
        if (we) begin
            exp_mem[a[7:2]] = wd;
            if (exp_wr != 16'hFFFF) exp_wr++;
        end else begin
            last_rd = RB ? exp_mem[a[7:2]] : 32'h0;
        end
        exp_q.push_back({32'h0, last_rd});
        exp_q.push_back({48'h0, exp_wr});
        w0 = we_cnt;
        @(negedge clk);
        chk("gap_stall", cpu_stall, 0);
        chk("gap_ack", sdu_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sdu_stall", cpu_stall, 1);
        chk("sdu_we", mem_we, we);
        chk("sdu_addr", mem_addr, (we || RB) ? addr : cpu_pc);
        chk("sdu_nop", cpu_instr, NOP);
        chk("sdu_ack0", sdu_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ack_hi", sdu_ack, 1);
        chk("ack_stall", cpu_stall, 1);
        chk("ack_we", mem_we, 0);
        chk("ack_rdata", sdu_rdata, exp_q.pop_front());
        chk("ack_wrcnt", wr_cnt, exp_q.pop_front());
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_ack", sdu_ack, 1);
            chk("hold_stall", cpu_stall, 1);
            chk("hold_we", mem_we, 0);
        end
        @(posedge clk); #1;
        sdu_req = 1'b0;
        @(posedge clk); #1;
        chk("we_pulses", we_cnt - w0, we ? 1 : 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h1000_0000 + i;
            exp_mem[i] = 32'h1000_0000 + i;
        end
        rstn = 1'b0; cpu_pc = '0; sdu_req = 1'b0; sdu_we = 1'b0;
        sdu_addr = '0; sdu_wdata = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_ack", sdu_ack, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wrcnt", wr_cnt, 0);
        chk("rst_rdata", sdu_rdata, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        chk("run_wrcnt", wr_cnt, 0);

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
        fetch(32'h10);
        txn(1'b0, 32'h10, 32'h0, 0, 1'b0);
        fetch(32'h4);

        // Back-to-back: req re-raised in the single S_CPU cycle after release.
        txn(1'b1, 32'h30, 32'hA0A0_0001, 0, 1'b0);
        txn(1'b1, 32'h34, 32'hA0A0_0002, 0, 1'b1);
        txn(1'b1, 32'h38, 32'hA0A0_0003, 0, 1'b1);
        txn(1'b1, 32'h3C, 32'hA0A0_0004, 0, 1'b1);
        fetch(32'h34);
        fetch(32'h3C);

        txn(1'b1, 32'h41, 32'h5555_AAAA, 10, 1'b0);
        fetch(32'h40);
        txn(1'b0, 32'h40, 32'h0, 2, 1'b0);

        // Reset asserted during the S_SDU cycle of a write.
        @(posedge clk); #1;
        cpu_pc = 32'h20;
        sdu_we = 1'b1; sdu_addr = 32'h20; sdu_wdata = 32'hBAD0_BAD0; sdu_req = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0; sdu_req = 1'b0;
        @(negedge clk);
        chk("rstw_we", mem_we, 0);
        @(posedge clk); #1;
        rstn = 1'b1; exp_wr = '0; last_rd = '0;
        @(negedge clk);
        chk("rstw_stall", cpu_stall, 0);
        chk("rstw_ack", sdu_ack, 0);
        chk("rstw_wrcnt", wr_cnt, exp_wr);
        chk("rstw_rdata", sdu_rdata, last_rd);
        chk("rstw_mem", cpu_instr, exp_mem[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
